// File: rtl/alu_seq_ctrl_if.sv
// Command, result and ALU-side signal bundle for the NAND/ROL sequencing controller.
// The controller is the slave; the command source, result sink and ALU sit on the master side.
interface alu_seq_ctrl_if #(
    parameter int W = 7
);
    // Command channel
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic [2:0]     cmd_cnt;

    // External combinational ALU
    logic           alu_en;
    logic           alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_r;
    logic           alu_flag;

    // Result channel
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_flag;
    logic           res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt,
        output alu_r, alu_flag,
        output res_ready,
        input  cmd_ready,
        input  alu_en, alu_op, alu_a, alu_b,
        input  res_valid, res_data, res_flag, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt,
        input  alu_r, alu_flag,
        input  res_ready,
        output cmd_ready,
        output alu_en, alu_op, alu_a, alu_b,
        output res_valid, res_data, res_flag, res_err
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that drives an external 1-cycle NAND / ROL-by-one ALU to run
// NAND, rotate-by-k and NAND-then-rotate commands, one command at a time.
module alu_seq_ctrl #(
    parameter int W = 7
) (
    input  logic          clk,
    input  logic          rst,      // synchronous, active low
    alu_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NAND = 2'd1,
        ROT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;
    localparam logic [1:0] OP_NROL = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic           flag_q, flag_d;
    logic           err_q, err_d;

    logic           cmd_ready;
    logic           alu_en;
    logic           alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           res_valid;
    logic [W-1:0]   res_data;

    // State register; reset wins over any command presented in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and outputs; everything idles at zero by default
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        flag_d    = flag_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        alu_en    = 1'b0;
        alu_op    = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        res_valid = 1'b0;
        res_data  = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    acc_d  = bus.cmd_a;
                    b_d    = bus.cmd_b;
                    cnt_d  = bus.cmd_cnt;
                    op_d   = bus.cmd_op;
                    flag_d = 1'b0;
                    err_d  = 1'b0;
                    case (bus.cmd_op)
                        OP_NAND, OP_NROL: state_d = NAND;
                        // rotate by zero is a pass-through of cmd_a
                        OP_ROL:           state_d = (bus.cmd_cnt != 3'd0) ? ROT : DONE;
                        OP_RSVD: begin
                            acc_d   = '0;
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                        default:          state_d = DONE;
                    endcase
                end
            end

            NAND: begin
                alu_en  = 1'b1;
                alu_op  = 1'b0;
                alu_a   = acc_q;
                alu_b   = b_q;
                acc_d   = bus.alu_r;
                flag_d  = bus.alu_flag;
                state_d = (op_q == OP_NROL && cnt_q != 3'd0) ? ROT : DONE;
            end

            ROT: begin
                // one ALU rotate per cycle; leave on the cycle that consumes the last count
                alu_en  = 1'b1;
                alu_op  = 1'b1;
                alu_a   = acc_q;
                acc_d   = bus.alu_r;
                flag_d  = bus.alu_flag;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                res_valid = 1'b1;
                res_data  = acc_q;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_en    = alu_en;
    assign bus.alu_op    = alu_op;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_flag  = flag_q;
    assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural NAND/ROL ALU on the master side.
module tb_alu_seq_ctrl;
    localparam int W = 7;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_seq_ctrl_if #(.W(W)) bus ();

    alu_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External ALU contract model
    logic [W-1:0] alu_res;
    assign alu_res      = bus.alu_op ? {bus.alu_a[W-2:0], bus.alu_a[W-1]} : ~(bus.alu_a & bus.alu_b);
    assign bus.alu_r    = alu_res;
    assign bus.alu_flag = (alu_res == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE, follow it to DONE, check the result and release it.
    // lat counts the cycle right after the accept edge as 1.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] cnt,
                           input logic [W-1:0] exp_data, input logic exp_flag, input logic exp_err,
                           input int exp_lat, input int exp_nand, input int exp_rot);
        int lat;
        int en_cyc;
        lat    = 0;
        en_cyc = 0;
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cnt   = cnt;
        tick();
        bus.cmd_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (bus.res_valid) begin
                lat = n;
                break;
            end
            if (bus.alu_en) begin
                if (en_cyc < exp_nand) begin
                    chk({tag, "_aluop_nand"}, 32'(bus.alu_op), 32'd0);
                end else begin
                    chk({tag, "_aluop_rot"}, 32'(bus.alu_op), 32'd1);
                    chk({tag, "_alub_rot"}, 32'(bus.alu_b), 32'd0);
                end
                en_cyc++;
            end
            tick();
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_alu_cycles"}, 32'(en_cyc), 32'(exp_nand + exp_rot));
        chk({tag, "_data"}, 32'(bus.res_data), 32'(exp_data));
        chk({tag, "_flag"}, 32'(bus.res_flag), 32'(exp_flag));
        chk({tag, "_err"}, 32'(bus.res_err), 32'(exp_err));
        chk({tag, "_done_alu_en"}, 32'(bus.alu_en), 32'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_idle_data"}, 32'(bus.res_data), 32'd0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.cmd_valid = 1'b1;          // must be ignored while in reset
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 7'b1010101;
        bus.cmd_b     = 7'b1100110;
        bus.cmd_cnt   = 3'd0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_alu_en",    32'(bus.alu_en), 32'd0);
        chk("rst_alu_a",     32'(bus.alu_a), 32'd0);
        chk("rst_res_data",  32'(bus.res_data), 32'd0);
        chk("rst_res_flag",  32'(bus.res_flag), 32'd0);
        chk("rst_res_err",   32'(bus.res_err), 32'd0);
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_alu_en", 32'(bus.alu_en), 32'd0);

        //      tag     op     a           b           cnt   data        flag  err   lat nand rot
        run_cmd("nand", 2'b00, 7'b1010101, 7'b1100110, 3'd0, 7'b0111011, 1'b0, 1'b0, 2, 1, 0);
        run_cmd("rol2", 2'b01, 7'b1000001, 7'b0000000, 3'd2, 7'b0000110, 1'b0, 1'b0, 3, 0, 2);
        run_cmd("nrol", 2'b10, 7'b1111111, 7'b1111111, 3'd3, 7'b0000000, 1'b1, 1'b0, 5, 1, 3);
        run_cmd("rsvd", 2'b11, 7'b1011010, 7'b0101010, 3'd5, 7'b0000000, 1'b0, 1'b1, 1, 0, 0);
        run_cmd("rol0", 2'b01, 7'b0010011, 7'b1111111, 3'd0, 7'b0010011, 1'b0, 1'b0, 1, 0, 0);
        run_cmd("rol7", 2'b01, 7'b0000001, 7'b0000000, 3'd7, 7'b0000001, 1'b0, 1'b0, 8, 0, 7);
        run_cmd("nflg", 2'b00, 7'b1111111, 7'b1111111, 3'd4, 7'b0000000, 1'b1, 1'b0, 2, 1, 0);
        run_cmd("nr0",  2'b10, 7'b1110000, 7'b0011100, 3'd0, 7'b1101111, 1'b0, 1'b0, 2, 1, 0);

        // Backpressure: result held in DONE while a new command waits
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 7'b0001111;
        bus.cmd_b     = 7'b0110011;
        tick();
        bus.cmd_op    = 2'b01;
        bus.cmd_a     = 7'b0010011;
        bus.cmd_cnt   = 3'd1;
        tick();
        chk("bp_valid0", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_hold_data",  32'(bus.res_data), 32'(7'b1111100));
            chk("bp_hold_flag",  32'(bus.res_flag), 32'd0);
            chk("bp_hold_err",   32'(bus.res_err), 32'd0);
            chk("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("bp_release_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("bp_next_ready",  32'(bus.cmd_ready), 32'd0);
        chk("bp_next_alu_en", 32'(bus.alu_en), 32'd1);
        chk("bp_next_alu_op", 32'(bus.alu_op), 32'd1);
        chk("bp_next_alu_a",  32'(bus.alu_a), 32'(7'b0010011));
        tick();
        chk("bp_next_valid", 32'(bus.res_valid), 32'd1);
        chk("bp_next_data",  32'(bus.res_data), 32'(7'b0100110));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Reset in the third cycle of a 7-step rotate
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_a     = 7'b0000001;
        bus.cmd_cnt   = 3'd7;
        tick();
        bus.cmd_valid = 1'b0;
        chk("mr_rot1_a", 32'(bus.alu_a), 32'(7'b0000001));
        tick();
        chk("mr_rot2_a", 32'(bus.alu_a), 32'(7'b0000010));
        tick();
        chk("mr_rot3_a", 32'(bus.alu_a), 32'(7'b0000100));
        chk("mr_rot3_valid", 32'(bus.res_valid), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_ready",  32'(bus.cmd_ready), 32'd1);
        chk("mr_valid",  32'(bus.res_valid), 32'd0);
        chk("mr_alu_en", 32'(bus.alu_en), 32'd0);
        chk("mr_alu_a",  32'(bus.alu_a), 32'd0);
        chk("mr_alu_op", 32'(bus.alu_op), 32'd0);
        chk("mr_data",   32'(bus.res_data), 32'd0);
        chk("mr_flag",   32'(bus.res_flag), 32'd0);
        tick();
        chk("mr_after_valid", 32'(bus.res_valid), 32'd0);
        chk("mr_after_alu_en", 32'(bus.alu_en), 32'd0);
        run_cmd("mr_recover", 2'b00, 7'b0000000, 7'b1010101, 3'd0, 7'b1111111, 1'b0, 1'b0, 2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
